divide: RTL

DIVIDE -- requirements
Module: divide

---
 rtl/divide.sv | 128 ++++++++++++
 1 files changed

// File: rtl/divide.sv
// divide: fixed-latency restoring shift-subtract divider with IDLE/BUSY/DONE FSM.
// Signed support is built only when DIVIDE_SIGNED_EN is defined; otherwise signed_op is ignored.
module divide #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic dz_q, dz_d;
  logic busy_q, busy_d, done_q, done_d, div_by_zero_q, div_by_zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0] sh;
  logic ge;
`ifdef DIVIDE_SIGNED_EN
  logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, sa, sb;
  assign sa    = signed_op & dividend[WIDTH-1];
  assign sb    = signed_op & divisor[WIDTH-1];
  assign a_abs = sa ? -dividend : dividend;
  assign b_abs = sb ? -divisor : divisor;
  // divide-by-zero keeps an all-ones quotient regardless of operand signs
  assign neg_quo_d = (state_q == IDLE) ? (sa ^ sb) & (divisor != '0) : neg_quo_q;
  assign neg_rem_d = (state_q == IDLE) ? sa : neg_rem_q;
  assign q_fix = neg_quo_q ? -quo_q : quo_q;
  assign r_fix = neg_rem_q ? -rem_q : rem_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign a_abs = dividend;
  assign b_abs = divisor;
  assign q_fix = quo_q;
  assign r_fix = rem_q;
`endif
  assign sh = {rem_q, quo_q[WIDTH-1]};
  assign ge = sh >= {1'b0, dvs_q};
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    dz_d          = dz_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = BUSY;
        cnt_d   = '0;
        rem_d   = '0;
        quo_d   = a_abs;
        dvs_d   = b_abs;
        dz_d    = divisor == '0;
      end
      BUSY: begin
        rem_d   = ge ? sh[WIDTH-1:0] - dvs_q : sh[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : BUSY;
      end
      DONE: begin
        state_d       = IDLE;
        done_d        = 1'b1;
        quotient_d    = q_fix;
        remainder_d   = r_fix;
        div_by_zero_d = dz_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == BUSY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      dz_q          <= dz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
endmodule
